arith_exec_unit: RTL and testbench

Responder end of the dispatch-to-functional-unit handshake: one adder/multiplier execution slot that accepts a start level from the dispatch unit and acknowledges it. It computes the result, then holds a completion flag until dispatch clears it. One instance sits behind each dispatch lane (lane 1, lane 2). It drives the busy, in-progress, complete and write-enable signals that dispatch and the register file consume.

---
 rtl/arith_exec_unit.sv | 181 ++++++++++++++++++
 tb/tb_arith_exec_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/arith_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : arith_exec_unit
// Description : Single-slot add/multiply execution unit sitting behind one
//               dispatch lane. It accepts a level start request, acknowledges
//               it for one cycle and runs the op for a configurable latency.
//               It then raises complete plus a one-cycle register-file write
//               strobe, and holds complete until dispatch clears it.
//
// Ports:
//   clk                           in   rising-edge clock
//   reset                         in   asynchronous active-low reset
//   start_adder                   in   level request: operand_a + operand_b
//   start_multiplier              in   level request: operand_a * operand_b
//   operand_a, operand_b          in   32-bit source operands
//   rd_in                         in   5-bit destination register
//   reset_complete                in   dispatch has consumed the result
//   busy                          out  unit cannot accept a new op
//   reset_instruction_in_progress out  one-cycle accept acknowledge
//   complete                      out  result valid, held until cleared
//   write_enable                  out  one-cycle register-file write strobe
//   rd_out                        out  latched destination register
//   result                        out  latched 32-bit result
//   reset_operation_complete      out  one-cycle acknowledge of reset_complete
//
// Revision    : 1.0  initial release
// ============================================================================
module arith_exec_unit #(
  parameter int ADD_LATENCY = 1,
  parameter int MUL_LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_adder,
  input  logic        start_multiplier,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic [4:0]  rd_in,
  input  logic        reset_complete,
  output logic        busy,
  output logic        reset_instruction_in_progress,
  output logic        complete,
  output logic        write_enable,
  output logic [4:0]  rd_out,
  output logic [31:0] result,
  output logic        reset_operation_complete
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    DONE  = 2'd2,
    CLEAR = 2'd3
  } state_t;

  // The counter is preloaded with LAT-1 so that the completion edge
  // lands exactly LAT edges after the accept edge.
  localparam logic [3:0] C_ADD_CNT = 4'(ADD_LATENCY - 1);
  localparam logic [3:0] C_MUL_CNT = 4'(MUL_LATENCY - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic [4:0]  rd_lat_q, rd_lat_d;
  logic        is_mul_q, is_mul_d;
  logic        busy_q, busy_d;
  logic        ack_q, ack_d;
  logic        complete_q, complete_d;
  logic        we_q, we_d;
  logic [4:0]  rd_out_q, rd_out_d;
  logic [31:0] result_q, result_d;
  logic        roc_q, roc_d;

  logic [31:0] w_sum;
  logic [31:0] w_prod;

  // Both operations wrap to 32 bits; the product keeps only its low word.
  assign w_sum  = op_a_q + op_b_q;
  assign w_prod = op_a_q * op_b_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    rd_lat_d   = rd_lat_q;
    is_mul_d   = is_mul_q;
    ack_d      = 1'b0;
    complete_d = complete_q;
    we_d       = 1'b0;
    rd_out_d   = rd_out_q;
    result_d   = result_q;
    roc_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_adder || start_multiplier) begin
          op_a_d   = operand_a;
          op_b_d   = operand_b;
          rd_lat_d = rd_in;
          // Add takes priority when both requests are raised together.
          is_mul_d = !start_adder;
          cnt_d    = start_adder ? C_ADD_CNT : C_MUL_CNT;
          ack_d    = 1'b1;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          result_d   = is_mul_q ? w_prod : w_sum;
          rd_out_d   = rd_lat_q;
          complete_d = 1'b1;
          we_d       = 1'b1;
          state_d    = DONE;
        end
      end
      DONE: begin
        if (reset_complete) begin
          complete_d = 1'b0;
          roc_d      = 1'b1;
          state_d    = CLEAR;
        end
      end
      CLEAR: begin
        // Wait for dispatch to drop its start so a held level is never
        // mistaken for a fresh request.
        if (!start_adder && !start_multiplier) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      op_a_q     <= 32'd0;
      op_b_q     <= 32'd0;
      rd_lat_q   <= 5'd0;
      is_mul_q   <= 1'b0;
      busy_q     <= 1'b0;
      ack_q      <= 1'b0;
      complete_q <= 1'b0;
      we_q       <= 1'b0;
      rd_out_q   <= 5'd0;
      result_q   <= 32'd0;
      roc_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      rd_lat_q   <= rd_lat_d;
      is_mul_q   <= is_mul_d;
      busy_q     <= busy_d;
      ack_q      <= ack_d;
      complete_q <= complete_d;
      we_q       <= we_d;
      rd_out_q   <= rd_out_d;
      result_q   <= result_d;
      roc_q      <= roc_d;
    end
  end

  assign busy                          = busy_q;
  assign reset_instruction_in_progress = ack_q;
  assign complete                      = complete_q;
  assign write_enable                  = we_q;
  assign rd_out                        = rd_out_q;
  assign result                        = result_q;
  assign reset_operation_complete      = roc_q;

endmodule
`default_nettype wire

// File: tb/tb_arith_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_arith_exec_unit
// Description : Directed-vector bench for arith_exec_unit with default
//               latencies (add 1, multiply 4).
// Revision    : 1.0  initial release
// ============================================================================
module tb_arith_exec_unit;

  logic        clk;
  logic        reset;
  logic        start_adder;
  logic        start_multiplier;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [4:0]  rd_in;
  logic        reset_complete;
  logic        busy;
  logic        reset_instruction_in_progress;
  logic        complete;
  logic        write_enable;
  logic [4:0]  rd_out;
  logic [31:0] result;
  logic        reset_operation_complete;

  int n_vec;
  int n_err;

  arith_exec_unit #(
    .ADD_LATENCY(1),
    .MUL_LATENCY(4)
  ) dut (
    .clk                          (clk),
    .reset                        (reset),
    .start_adder                  (start_adder),
    .start_multiplier             (start_multiplier),
    .operand_a                    (operand_a),
    .operand_b                    (operand_b),
    .rd_in                        (rd_in),
    .reset_complete               (reset_complete),
    .busy                         (busy),
    .reset_instruction_in_progress(reset_instruction_in_progress),
    .complete                     (complete),
    .write_enable                 (write_enable),
    .rd_out                       (rd_out),
    .result                       (result),
    .reset_operation_complete     (reset_operation_complete)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},     {31'd0, busy}, 32'd0);
    check({tag, "_ack"},      {31'd0, reset_instruction_in_progress}, 32'd0);
    check({tag, "_complete"}, {31'd0, complete}, 32'd0);
    check({tag, "_we"},       {31'd0, write_enable}, 32'd0);
    check({tag, "_rd_out"},   {27'd0, rd_out}, 32'd0);
    check({tag, "_result"},   result, 32'd0);
    check({tag, "_roc"},      {31'd0, reset_operation_complete}, 32'd0);
  endtask

  // Full transaction: accept, run, complete, clear, return to idle.
  task automatic do_op(input string tag, input bit sa, input bit sm,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp, input int lat);
    start_adder      = sa;
    start_multiplier = sm;
    operand_a        = a;
    operand_b        = b;
    rd_in            = rd;
    tick();
    check({tag, "_ack"},  {31'd0, reset_instruction_in_progress}, 32'd1);
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    start_adder      = 1'b0;
    start_multiplier = 1'b0;
    operand_a        = 32'hDEAD_BEEF;
    operand_b        = 32'hCAFE_F00D;
    rd_in            = 5'd31;
    for (int i = 1; i < lat; i++) begin
      tick();
      check({tag, "_early_complete"}, {31'd0, complete}, 32'd0);
      check({tag, "_ack_once"}, {31'd0, reset_instruction_in_progress}, 32'd0);
    end
    tick();
    check({tag, "_complete"}, {31'd0, complete}, 32'd1);
    check({tag, "_we"},       {31'd0, write_enable}, 32'd1);
    check({tag, "_result"},   result, exp);
    check({tag, "_rd_out"},   {27'd0, rd_out}, {27'd0, rd});
    tick();
    check({tag, "_we_drop"},  {31'd0, write_enable}, 32'd0);
    check({tag, "_hold"},     {31'd0, complete}, 32'd1);
    reset_complete = 1'b1;
    tick();
    reset_complete = 1'b0;
    check({tag, "_cleared"},  {31'd0, complete}, 32'd0);
    check({tag, "_roc"},      {31'd0, reset_operation_complete}, 32'd1);
    check({tag, "_clr_busy"}, {31'd0, busy}, 32'd1);
    tick();
    check({tag, "_roc_drop"}, {31'd0, reset_operation_complete}, 32'd0);
    check({tag, "_idle"},     {31'd0, busy}, 32'd0);
    check({tag, "_persist"},  result, exp);
  endtask

  initial begin
    n_vec            = 0;
    n_err            = 0;
    reset            = 1'b0;
    start_adder      = 1'b0;
    start_multiplier = 1'b0;
    operand_a        = 32'd0;
    operand_b        = 32'd0;
    rd_in            = 5'd0;
    reset_complete   = 1'b0;

    tick();
    tick();
    check_all_zero("rst");
    reset = 1'b1;
    tick();

    do_op("add",   1'b1, 1'b0, 32'd7,          32'd5,          5'd3,  32'd12, 1);
    do_op("mul",   1'b0, 1'b1, 32'd3,          32'd4,          5'd9,  32'd12, 4);
    do_op("addwr", 1'b1, 1'b0, 32'hFFFF_FFFF,  32'd2,          5'd1,  32'd1,  1);
    do_op("mulwr", 1'b0, 1'b1, 32'h0001_0000,  32'h0001_0000,  5'd17, 32'd0,  4);
    do_op("both",  1'b1, 1'b1, 32'd6,          32'd7,          5'd4,  32'd13, 1);
    do_op("mul42", 1'b0, 1'b1, 32'd6,          32'd7,          5'd5,  32'd42, 4);

    // Held start: the unit must sit in CLEAR without re-accepting.
    start_adder = 1'b1;
    operand_a   = 32'd10;
    operand_b   = 32'd20;
    rd_in       = 5'd7;
    tick();
    check("held_ack", {31'd0, reset_instruction_in_progress}, 32'd1);
    tick();
    check("held_result", result, 32'd30);
    reset_complete = 1'b1;
    tick();
    reset_complete = 1'b0;
    check("held_roc", {31'd0, reset_operation_complete}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("held_busy", {31'd0, busy}, 32'd1);
      check("held_no_ack", {31'd0, reset_instruction_in_progress}, 32'd0);
    end
    start_adder = 1'b0;
    tick();
    check("held_release_idle", {31'd0, busy}, 32'd0);
    check("held_release_no_ack", {31'd0, reset_instruction_in_progress}, 32'd0);

    // Reset in the middle of a multiply.
    start_multiplier = 1'b1;
    operand_a        = 32'd9;
    operand_b        = 32'd9;
    rd_in            = 5'd12;
    tick();
    start_multiplier = 1'b0;
    tick();
    tick();
    check("midrst_busy_pre", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    check_all_zero("midrst");
    for (int i = 0; i < 4; i++) begin
      tick();
      check("midrst_no_complete", {31'd0, complete}, 32'd0);
    end
    reset = 1'b1;
    tick();
    check("midrst_after_release", {31'd0, complete}, 32'd0);
    do_op("post", 1'b1, 1'b0, 32'd1, 32'd1, 5'd2, 32'd2, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
